// File: rtl/fetch_queue_pkg.sv
// fetch_pkg: shared constants, queue entry type and width helper for the fetch queue.
package fetch_pkg;
    localparam int INST_W = 32;
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;
    localparam int XLEN_DEF = 32;
    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [INST_W-1:0]   inst;
    } fq_entry_t;
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: instruction-memory request/response and decode handshake signals.
interface fetch_queue_if #(parameter int XLEN = 32);
    logic                        imem_req_o;
    logic [XLEN-1:0]             imem_addr_o;
    logic                        imem_rvalid_i;
    logic [fetch_pkg::INST_W-1:0] imem_rdata_i;
    logic                        inst_valid_o;
    logic [fetch_pkg::INST_W-1:0] inst_o;
    logic [XLEN-1:0]             pc_o;
    logic                        inst_ready_i;
    modport master (
        output imem_req_o, imem_addr_o, inst_valid_o, inst_o, pc_o,
        input  imem_rvalid_i, imem_rdata_i, inst_ready_i
    );
    modport slave (
        input  imem_req_o, imem_addr_o, inst_valid_o, inst_o, pc_o,
        output imem_rvalid_i, imem_rdata_i, inst_ready_i
    );
endinterface

// File: rtl/fetch_queue_fifo.sv
// fq_fifo: DEPTH-entry FIFO with flush; pointers carry an extra wrap bit for full/empty.
module fq_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fq_entry_t
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  T                         i_data,
    output T                         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0] r_wp, r_rp;
    T            r_mem [DEPTH];

    assign o_count = r_wp - r_rp;
    assign o_empty = r_wp == r_rp;
    assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign o_data  = r_mem[r_rp[AW-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wp <= '0;
            r_rp <= '0;
        end else if (i_flush) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (i_push) r_wp <= r_wp + (AW+1)'(1);
            if (i_pop)  r_rp <= r_rp + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (i_push && !i_flush) r_mem[r_wp[AW-1:0]] <= i_data;
    end

    // credit accounting upstream must make this impossible
    assert property (@(posedge clk_i) disable iff (rst_i) !(i_push && o_full && !i_flush));
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: credit-limited sequential prefetch into a DEPTH-entry queue with redirect flush.
// Define FETCH_QUEUE_BYPASS_EN to forward a response straight to decode when the queue is empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     redirect_i,
    input  logic [XLEN-1:0]          redirect_pc_i,
    output logic [cnt_w(DEPTH)-1:0]  occupancy_o,
    fetch_queue_if.master            bus
);
    localparam int CW = cnt_w(DEPTH);
    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    logic [XLEN-1:0] r_pc, r_rsp_pc;
    logic [CW-1:0]   r_out, r_drop;
    logic [CW-1:0]   w_count;
    logic            w_empty, w_full, w_accept, w_byp, w_valid, w_push, w_pop, w_req;
    entry_t          w_head, w_wdata;

    assign w_wdata  = '{pc: r_rsp_pc, inst: bus.imem_rdata_i};
    assign w_accept = bus.imem_rvalid_i & (r_drop == '0);
`ifdef FETCH_QUEUE_BYPASS_EN
    assign w_byp    = w_empty & w_accept & ~redirect_i;
`else
    assign w_byp    = 1'b0;
`endif
    assign w_valid  = (~w_empty | w_byp) & ~redirect_i;
    assign w_pop    = ~w_empty & w_valid & bus.inst_ready_i;
    assign w_push   = w_accept & ~redirect_i & ~(w_byp & bus.inst_ready_i);
    assign w_req    = ~rst_i & start_i & ~redirect_i & ~w_full &
                      (({1'b0, w_count} + {1'b0, r_out}) < (CW+1)'(DEPTH));

    assign bus.imem_req_o   = w_req;
    assign bus.imem_addr_o  = r_pc;
    assign bus.inst_valid_o = w_valid;
    assign bus.inst_o       = w_valid ? (w_empty ? bus.imem_rdata_i : w_head.inst) : '0;
    assign bus.pc_o         = w_valid ? (w_empty ? r_rsp_pc : w_head.pc) : '0;
    assign occupancy_o      = w_count;

    fq_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_i),
        .i_data  (w_wdata),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // responses still in flight at a redirect belong to the old path and are dropped
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pc     <= RESET_PC;
            r_rsp_pc <= RESET_PC;
            r_out    <= '0;
            r_drop   <= '0;
        end else begin
            r_out <= r_out + CW'(w_req) - CW'(bus.imem_rvalid_i);
            if (redirect_i) begin
                r_pc     <= {redirect_pc_i[XLEN-1:2], 2'b00};
                r_rsp_pc <= {redirect_pc_i[XLEN-1:2], 2'b00};
                r_drop   <= r_out - CW'(bus.imem_rvalid_i);
            end else begin
                if (w_req) r_pc <= r_pc + XLEN'(PC_STEP);
                if (w_accept) r_rsp_pc <= r_rsp_pc + XLEN'(PC_STEP);
                if (bus.imem_rvalid_i && !w_accept) r_drop <= r_drop - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: vector table, directed corner sequences and random traffic against a queue-based model.
module tb_fetch_queue;
    import fetch_pkg::*;
    localparam int XLEN    = 32;
    localparam int DEPTH   = 4;
    localparam int PC_STEP = 4;
    localparam int CW      = $clog2(DEPTH + 1);
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk_i = 1'b0, rst_i = 1'b1, start_i = 1'b0, redirect_i = 1'b0;
    logic [XLEN-1:0] redirect_pc_i = '0;
    logic [CW-1:0]   occupancy_o;

    fetch_queue_if #(.XLEN(XLEN)) bus ();

    fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC('0), .PC_STEP(PC_STEP)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .occupancy_o   (occupancy_o),
        .bus           (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { int due; logic [31:0] addr; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
    typedef struct { logic [31:0] addr; bit stale; } fl_t;
    typedef struct {
        bit rst_before; bit start; bit ready;
        bit e_req; logic [31:0] e_addr; bit e_valid; logic [31:0] e_pc; int e_occ;
    } vec_t;

    mreq_t       mem[$];
    ent_t        mq[$];
    fl_t         inflight[$];
    logic [31:0] m_fpc;
    int          lat = 1, last_due = 0, cyc = 0;
    int          errors = 0, checks = 0;
    bit          rv, byp, e_req, e_valid, d_req;
    logic [31:0] d_addr, e_pc, e_inst;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        inflight.delete();
        mem.delete();
        m_fpc    = '0;
        last_due = 0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        start_i = 1'b0;
        redirect_i = 1'b0;
        bus.inst_ready_i = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i = '0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
    endtask

    // drive memory response, then compare DUT against model expectations
    task automatic pre();
        bit front_ok;
        rv = mem.size() > 0 && mem[0].due <= cyc;
        bus.imem_rvalid_i = rv;
        bus.imem_rdata_i  = rv ? data_of(mem[0].addr) : '0;
        #1;
        front_ok = inflight.size() > 0 && !inflight[0].stale;
        e_req    = start_i && !redirect_i && (mq.size() + inflight.size() < DEPTH);
        byp      = BYP && mq.size() == 0 && rv && front_ok && !redirect_i;
        e_valid  = (mq.size() > 0 || byp) && !redirect_i;
        e_pc = '0;
        e_inst = '0;
        if (mq.size() > 0) begin
            e_pc = mq[0].pc;
            e_inst = mq[0].inst;
        end else if (byp) begin
            e_pc = inflight[0].addr;
            e_inst = data_of(inflight[0].addr);
        end
        chk("imem_req", bus.imem_req_o, e_req);
        chk("imem_addr", bus.imem_addr_o, m_fpc);
        chk("inst_valid", bus.inst_valid_o, e_valid);
        if (e_valid) begin
            chk("pc", bus.pc_o, e_pc);
            chk("inst", bus.inst_o, e_inst);
        end
        chk("occupancy", occupancy_o, mq.size());
        d_req  = bus.imem_req_o;
        d_addr = bus.imem_addr_o;
    endtask

    task automatic post();
        fl_t f;
        bit  keep;
        int  due;
        @(posedge clk_i);
        keep = 1'b0;
        if (rv && inflight.size() > 0) begin
            f = inflight.pop_front();
            keep = !f.stale;
        end
        if (redirect_i) begin
            mq.delete();
            foreach (inflight[i]) inflight[i].stale = 1'b1;
            m_fpc = {redirect_pc_i[31:2], 2'b00};
        end else begin
            if (e_valid && bus.inst_ready_i) begin
                if (mq.size() > 0) mq.delete(0);
                else keep = 1'b0;
            end
            if (keep) mq.push_back('{pc: f.addr, inst: data_of(f.addr)});
        end
        if (e_req) begin
            inflight.push_back('{addr: m_fpc, stale: 1'b0});
            m_fpc += PC_STEP;
        end
        if (rv) mem.delete(0);
        if (d_req) begin
            due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            mem.push_back('{due: due, addr: d_addr});
            last_due = due;
        end
        cyc++;
        #1;
    endtask

    task automatic wait_pc(input string name, input logic [31:0] want);
        bit found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            pre();
            if (bus.inst_valid_o) begin
                chk(name, bus.pc_o, want);
                found = 1'b1;
            end
            post();
        end
        if (!found) chk({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        vec_t tbl[16];
        int   n = 0;
        bus.inst_ready_i = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i = '0;
        #3;
        chk("reset_req", bus.imem_req_o, 0);
        chk("reset_valid", bus.inst_valid_o, 0);
        chk("reset_occ", occupancy_o, 0);
        chk("reset_addr", bus.imem_addr_o, 0);

`ifndef FETCH_QUEUE_BYPASS_EN
        tbl[n++] = '{1, 1, 1, 1, 32'h00, 0, 32'h00, 0};
        tbl[n++] = '{0, 1, 1, 1, 32'h04, 0, 32'h00, 0};
        tbl[n++] = '{0, 1, 1, 1, 32'h08, 1, 32'h00, 1};
        tbl[n++] = '{0, 1, 1, 1, 32'h0C, 1, 32'h04, 1};
        tbl[n++] = '{0, 1, 1, 1, 32'h10, 1, 32'h08, 1};
        tbl[n++] = '{1, 1, 0, 1, 32'h00, 0, 32'h00, 0};
        tbl[n++] = '{0, 1, 0, 1, 32'h04, 0, 32'h00, 0};
        tbl[n++] = '{0, 1, 0, 1, 32'h08, 1, 32'h00, 1};
        tbl[n++] = '{0, 1, 0, 1, 32'h0C, 1, 32'h00, 2};
        tbl[n++] = '{0, 1, 0, 0, 32'h10, 1, 32'h00, 3};
        tbl[n++] = '{0, 1, 0, 0, 32'h10, 1, 32'h00, 4};
        tbl[n++] = '{0, 1, 1, 0, 32'h10, 1, 32'h00, 4};
        tbl[n++] = '{0, 1, 1, 1, 32'h10, 1, 32'h04, 3};
        tbl[n++] = '{0, 1, 1, 1, 32'h14, 1, 32'h08, 2};
        tbl[n++] = '{0, 1, 1, 1, 32'h18, 1, 32'h0C, 2};
        tbl[n++] = '{0, 1, 1, 1, 32'h1C, 1, 32'h10, 2};
        lat = 1;
        for (int i = 0; i < n; i++) begin
            if (tbl[i].rst_before) do_reset();
            start_i = tbl[i].start;
            bus.inst_ready_i = tbl[i].ready;
            pre();
            chk("tbl_req", bus.imem_req_o, tbl[i].e_req);
            if (tbl[i].e_req) chk("tbl_addr", bus.imem_addr_o, tbl[i].e_addr);
            chk("tbl_valid", bus.inst_valid_o, tbl[i].e_valid);
            if (tbl[i].e_valid) chk("tbl_pc", bus.pc_o, tbl[i].e_pc);
            chk("tbl_occ", occupancy_o, tbl[i].e_occ);
            post();
        end
`else
        do_reset();
        lat = 1;
        start_i = 1'b1;
        bus.inst_ready_i = 1'b1;
        pre(); post();
        pre();
        chk("byp_valid", bus.inst_valid_o, 1);
        chk("byp_pc", bus.pc_o, 0);
        chk("byp_occ", occupancy_o, 0);
        post();
        pre();
        chk("byp_occ_after", occupancy_o, 0);
        post();
`endif

        // redirect with two slow responses outstanding
        do_reset();
        lat = 3;
        start_i = 1'b1;
        bus.inst_ready_i = 1'b1;
        pre(); post();
        pre(); post();
        redirect_i = 1'b1;
        redirect_pc_i = 32'h100;
        pre();
        chk("redir_noreq", bus.imem_req_o, 0);
        post();
        redirect_i = 1'b0;
        wait_pc("redir_first_pc", 32'h100);

        // redirect colliding with a ready decode and an arriving response
        do_reset();
        lat = 1;
        start_i = 1'b1;
        bus.inst_ready_i = 1'b0;
        repeat (4) begin pre(); post(); end
        bus.inst_ready_i = 1'b1;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h103;
        pre();
        chk("redir_ready_valid", bus.inst_valid_o, 0);
        post();
        redirect_i = 1'b0;
        pre();
        chk("redir_ready_occ", occupancy_o, 0);
        chk("redir_ready_addr", bus.imem_addr_o, 32'h100);
        post();
        wait_pc("redir_ready_pc", 32'h100);

        // asynchronous reset with three entries queued
        do_reset();
        lat = 1;
        start_i = 1'b1;
        bus.inst_ready_i = 1'b0;
        repeat (4) begin pre(); post(); end
        pre();
        chk("pre_rst_occ", occupancy_o, 3);
        #2 rst_i = 1'b1;
        bus.imem_rvalid_i = 1'b0;
        #1;
        chk("async_rst_req", bus.imem_req_o, 0);
        chk("async_rst_valid", bus.inst_valid_o, 0);
        chk("async_rst_occ", occupancy_o, 0);
        chk("async_rst_addr", bus.imem_addr_o, 0);
        model_reset();
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        pre();
        chk("restart_addr", bus.imem_addr_o, 0);
        post();
        pre(); post();

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 800; i++) begin
            start_i = $urandom_range(0, 7) != 0;
            bus.inst_ready_i = $urandom_range(0, 2) != 0;
            redirect_i = $urandom_range(0, 15) == 0;
            redirect_pc_i = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            lat = $urandom_range(1, 4);
            pre();
            post();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction-fetch front end that generalises the single-entry PC/IFID fetch path into a prefetch queue of DEPTH entries.
- Issues sequential PC requests to instruction memory and buffers returned instructions with their PCs.
- Delivers them to decode over a valid/ready handshake.
- Discards queued and in-flight instructions on a branch redirect. Sits between instruction memory and the IF/ID boundary.

Parameters:
- XLEN, 32, PC and address width.
- DEPTH, 4, queue entries; power of two, 2..16.
- RESET_PC, 0, PC after reset.
- PC_STEP, 4, sequential PC increment.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset, asynchronous, active-high
- start_i  input  1  fetch enable; low = no new requests, queue state held
- imem_req_o  input/output: output  1  fetch request this cycle
- imem_addr_o  output  XLEN  fetch address, valid with imem_req_o
- imem_rvalid_i  input  1  response valid; in order, one per request, latency >= 1 cycle
- imem_rdata_i  input  32  fetched instruction
- redirect_i  input  1  flush and restart fetch (branch taken)
- redirect_pc_i  input  XLEN  new fetch PC
- inst_valid_o  output  1  head entry valid to decode
- inst_o  output  32  head instruction
- pc_o  output  XLEN  head PC
- inst_ready_i  input  1  decode accepts; low = stall
- occupancy_o  output  $clog2(DEPTH+1)  queued entries

Behaviour:
- Reset (async assert): fetch PC = RESET_PC; queue empty; outstanding = 0; drop count = 0. All outputs 0; occupancy_o = 0.
- Request issue:
  - imem_req_o = start_i & ~redirect_i & (occupancy + outstanding < DEPTH).
  - imem_addr_o = fetch PC.
  - On issue, fetch PC += PC_STEP, wrapping modulo 2^XLEN, and outstanding increments.
- Response:
  - imem_rvalid_i decrements outstanding.
  - If drop count > 0, the response is discarded and drop count decrements.
  - Otherwise {pc, inst} is written at the tail. The pc is tracked by a separate response-PC counter advancing PC_STEP per accepted response.
  - The credit rule means the queue never overflows; a response arriving with the queue full is an assertion failure.
- Output:
  - inst_valid_o = ~empty & ~redirect_i.
  - Handshake = inst_valid_o & inst_ready_i; it pops the head at the clock edge.
  - Simultaneous push and pop keeps occupancy unchanged.
- Redirect (one cycle pulse, registered effect):
  - The queue empties at the next edge.
  - Drop count = outstanding minus any response arriving this cycle.
  - Fetch PC and response PC = redirect_pc_i with bits [1:0] cleared.
  - No request is issued and no handshake completes in the redirect cycle.
  - Back-to-back redirects: the last one wins; drop count accumulates correctly.
- Latency (1-cycle memory, queue empty, no bypass): request at cycle N, response at N+1, inst_valid_o at N+2.
- start_i low mid-operation: outstanding responses still land; decode may still drain the queue.
- Reset mid-operation: all state cleared immediately. Responses arriving after reset release are the memory's responsibility; the bench holds rdata invalid for 2 cycles.
- Wrap-around: queue pointers use DEPTH-modulo indices with an extra wrap bit for full/empty.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- With it: when the queue is empty, drop count = 0, and an accepted response arrives, the response drives inst_o/pc_o/inst_valid_o combinationally in the same cycle. If inst_ready_i is high it is consumed without a write; otherwise it is written normally. First-instruction latency drops to N+1.
- Without it: every response goes through the queue, giving the N+2 latency above.

Decomposition:
- Package fetch_pkg:
  - INST_W = 32.
  - NOP_INST = 32'h00000013.
  - Typedef fq_entry_t {pc[XLEN], inst[32]}.
  - Function clog2-based width helper.
- One sub-module, fq_fifo: synchronous DEPTH-entry FIFO of fq_entry_t with push/pop/flush/full/empty/count and async active-high reset.
- Credit, drop and PC logic stay in fetch_queue.

Test Plan:
- Reset release, start_i=1, ready=1, 1-cycle memory -> imem_addr_o 0,4,8...; first inst_valid_o 2 cycles after first request with pc_o=0; then one instruction per cycle.
- ready=0 throughout -> exactly 4 requests (0x0..0xC), imem_req_o then low, occupancy_o=4. Raise ready -> pc_o 0,4,8,C in order, then requests resume at 0x10.
- 3-cycle memory latency, redirect to 0x100 with 2 responses outstanding -> both responses discarded, queue empty, next issued and delivered pc_o=0x100.
- redirect_i and inst_ready_i high with valid head in same cycle -> inst_valid_o=0, no pop counted. redirect_pc_i=0x103 -> fetch at 0x100.
- rst_i pulsed mid-stream with 3 entries queued -> outputs 0 asynchronously, occupancy 0; after release fetch restarts at RESET_PC.
- FETCH_QUEUE_BYPASS_EN defined, empty queue, ready=1 -> inst_valid_o in same cycle as imem_rvalid_i, occupancy_o stays 0.
